mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master arbiter for the native valid/ready memory bus: shares one downstream port (RAM/iomem
//  region) between the CPU (m0) and the data-processing DMA master (m1). Round-robin, one
//  transaction per grant, watchdog completes stalled transfers. Sits between masters and the SoC decoder.
// PARAMETERS
//  TIMEOUT_CYCLES  255  granted cycles without s_ready before forced completion; 0 disables watchdog
//  CNT_W           8    watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W
//  TIMEOUT_RDATA   32'hFFFF_FFFF  read data returned on a timed-out transfer
// PORTS
//  clk          in   1   clock, all flops on rising edge
//  resetn       in   1   asynchronous active-low reset
//  m0_valid     in   1   CPU request; held until m0_ready
//  m0_addr      in   32  CPU address
//  m0_wdata     in   32  CPU write data
//  m0_wstrb     in   4   CPU byte strobes; 0 = read
//  m0_ready     out  1   CPU transfer complete
//  m0_rdata     out  32  CPU read data, valid when m0_ready
//  m1_valid/m1_addr/m1_wdata/m1_wstrb/m1_ready/m1_rdata   same as m0_*, DMA master
//  s_valid      out  1   downstream request
//  s_addr       out  32  downstream address (muxed from granted master)
//  s_wdata      out  32  downstream write data
//  s_wstrb      out  4   downstream strobes
//  s_ready      in   1   downstream completion (may be combinational from s_valid)
//  s_rdata      in   32  downstream read data
//  grant        out  2   one-hot current owner {m1,m0}; 2'b00 when idle
//  timeout_irq  out  1   one-cycle pulse on forced completion
//  timeout_src  out  1   sticky: master of last timed-out transfer (0=m0, 1=m1)
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE, grant=00, rr_ptr=0 (m0 preferred), watchdog=0,
//   timeout_irq=0, timeout_src=0; s_valid, m0_ready, m1_ready=0; data outputs 0.
//  States: IDLE, GNT0, GNT1 (registered).
//  IDLE: s_valid=0. Both valid -> grant master rr_ptr; one valid -> grant it; none -> stay.
//   Transition at next edge; arbitration latency 1 cycle (request seen cycle N, s_valid cycle N+1).
//  GNTx: s_valid=mx_valid; s_addr/s_wdata/s_wstrb = mx_*; mx_ready=s_ready; mx_rdata=s_rdata;
//   other master's ready=0, rdata=0. Pure combinational forward, no added latency in grant.
//  Completion: s_valid && s_ready in GNTx -> IDLE, rr_ptr=~x (other master preferred next).
//   Always one IDLE cycle between transfers; a master keeping valid high re-arbitrates normally.
//  Master drops valid while granted (protocol violation): -> IDLE, rr_ptr unchanged, no irq.
//  Watchdog: in GNTx, counter +1 per cycle with s_ready=0, cleared on IDLE entry.
//   Count reaches TIMEOUT_CYCLES-1 with s_ready=0 on that cycle: force mx_ready=1,
//   mx_rdata=TIMEOUT_RDATA, s_valid=0 that cycle; timeout_irq=1 next cycle for exactly one cycle;
//   timeout_src=x; -> IDLE, rr_ptr=~x. s_ready=1 on that same cycle wins (normal completion).
//  Writes never split or reordered; strobes passed unmodified; ungranted master sees ready=0.
//  Reset mid-transfer: immediate abort to IDLE, no ready issued; downstream must tolerate
//   s_valid dropping.
//  No combinational path m*_valid -> m*_ready other than through s_ready (grant is registered).
// STRUCTURE
//  Package mem_bus_pkg: state encodings (ST_IDLE/ST_GNT0/ST_GNT1), TIMEOUT_RDATA default,
//   bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
//  Sub-module rr_pick2: combinational 2-way round-robin pick (req[1:0], ptr -> onehot);
//   rest (FSM, mux, watchdog) flat in this module.
// TESTING
//  1 m0 read alone, s_ready 2 cycles after s_valid, s_rdata=32'h1234_5678 -> grant=01 one cycle
//    after m0_valid, m0_rdata=32'h1234_5678 with m0_ready, m1_ready never 1.
//  2 m0 and m1 valid same cycle from reset -> m0 served first, then IDLE cycle, then m1;
//    repeat both -> m1 first (rr_ptr alternates); s_addr tracks grant.
//  3 m1 write wstrb=4'b0011 wdata=32'hAABB_CCDD, s_ready combinational -> s_wstrb=0011,
//    s_wdata=AABB_CCDD; m1_ready same cycle as s_valid.
//  4 TIMEOUT_CYCLES=8, s_ready held 0 on m1 read -> m1_ready on 8th granted cycle with
//    rdata=FFFF_FFFF, s_valid=0 that cycle, timeout_irq pulse 1 cycle, timeout_src=1.
//  5 s_ready rises on exact timeout cycle -> normal completion, real s_rdata, no timeout_irq.
//  6 resetn low mid-GNT0 -> grant=00, s_valid=0 asynchronously; after release m0 re-arbitrated.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: state encoding,
// bus field widths and the read data returned on a watchdog-forced completion.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DFLT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the master named by ptr.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready memory bus, one transaction
// per grant, with a watchdog that force-completes stalled transfers.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter int                 CNT_W          = 8,
    parameter logic [DATA_W-1:0]  TIMEOUT_RDATA  = TIMEOUT_RDATA_DFLT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic              timeout_irq,
    output logic              timeout_src
);

    localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state_reg;
    logic [1:0]       grant_reg;
    logic             rr_ptr_reg;
    logic [CNT_W-1:0] wd_cnt_reg;
    logic             timeout_irq_reg;
    logic             timeout_src_reg;

    logic [1:0] pick;
    logic       granted;
    logic       sel;
    logic       sel_valid;
    logic       wd_fire;

    rr_pick2 u_pick (
        .req  ({m1_valid, m0_valid}),
        .ptr  (rr_ptr_reg),
        .pick (pick)
    );

    // The watchdog fire term deliberately ignores master valid so that the
    // only valid->ready path stays the one through s_ready.
    always_comb begin
        granted   = (state_reg == ST_GNT0) || (state_reg == ST_GNT1);
        sel       = (state_reg == ST_GNT1);
        sel_valid = granted && (sel ? m1_valid : m0_valid);
        wd_fire   = WD_EN && granted && !s_ready && (wd_cnt_reg == WD_LAST);
    end

    always_comb begin
        s_valid  = sel_valid && !wd_fire;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (state_reg == ST_GNT0) begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = s_ready || wd_fire;
            m0_rdata = wd_fire ? TIMEOUT_RDATA : s_rdata;
        end else if (state_reg == ST_GNT1) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = s_ready || wd_fire;
            m1_rdata = wd_fire ? TIMEOUT_RDATA : s_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= 2'b00;
            rr_ptr_reg      <= 1'b0;
            wd_cnt_reg      <= '0;
            timeout_irq_reg <= 1'b0;
            timeout_src_reg <= 1'b0;
        end else begin
            timeout_irq_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    wd_cnt_reg <= '0;
                    if (pick[0]) begin
                        state_reg <= ST_GNT0;
                        grant_reg <= 2'b01;
                    end else if (pick[1]) begin
                        state_reg <= ST_GNT1;
                        grant_reg <= 2'b10;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    // Abandoned request: release without moving the pointer.
                    if (!sel_valid) begin
                        state_reg  <= ST_IDLE;
                        grant_reg  <= 2'b00;
                        wd_cnt_reg <= '0;
                    end else if (s_ready || wd_fire) begin
                        state_reg       <= ST_IDLE;
                        grant_reg       <= 2'b00;
                        wd_cnt_reg      <= '0;
                        rr_ptr_reg      <= ~sel;
                        if (!s_ready) begin
                            timeout_irq_reg <= 1'b1;
                            timeout_src_reg <= sel;
                        end
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    grant_reg  <= 2'b00;
                    wd_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign timeout_irq = timeout_irq_reg;
    assign timeout_src = timeout_src_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a directed vector table, hand-written
// multi-cycle corner sequences and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_irq, timeout_src;

    logic comb_ready;
    logic s_ready_drv;
    assign s_ready = comb_ready ? s_valid : s_ready_drv;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_irq(timeout_irq), .timeout_src(timeout_src)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          v0, v1, srdy;
        logic [31:0] srd;
        logic [1:0]  e_grant;
        bit          e_sv, e_r0, e_r1;
        logic [31:0] e_rd0, e_rd1, e_addr;
    } vec_t;

    function automatic vec_t mk(bit v0, bit v1, bit srdy, logic [31:0] srd, logic [1:0] g,
                                bit sv, bit r0, bit r1, logic [31:0] rd0, logic [31:0] rd1,
                                logic [31:0] addr);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.srdy = srdy; v.srd = srd;
        v.e_grant = g; v.e_sv = sv; v.e_r0 = r0; v.e_r1 = r1;
        v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_addr = addr;
        return v;
    endfunction

    // Transaction-level reference: who owns the bus, who is preferred next,
    // how long the owner has waited, and the pending interrupt / sticky source.
    int mo_owner, mo_pref, mo_wait;
    bit mo_irq, mo_src;

    task automatic model_reset();
        mo_owner = -1; mo_pref = 0; mo_wait = 0; mo_irq = 0; mo_src = 0;
    endtask

    task automatic model_eval(output logic [159:0] e, output bit r0, output bit r1, output bit fire);
        bit v; logic [1:0] g; bit sv;
        logic [31:0] rd0, rd1, a, wd; logic [3:0] ws;
        g = 0; sv = 0; r0 = 0; r1 = 0; rd0 = 0; rd1 = 0; a = 0; wd = 0; ws = 0; fire = 0; v = 0;
        if (mo_owner >= 0) begin
            v    = (mo_owner == 0) ? m0_valid : m1_valid;
            fire = (TO > 0) && !s_ready && (mo_wait == TO - 1);
            g    = (mo_owner == 0) ? 2'b01 : 2'b10;
            sv   = v && !fire;
            a    = (mo_owner == 0) ? m0_addr  : m1_addr;
            wd   = (mo_owner == 0) ? m0_wdata : m1_wdata;
            ws   = (mo_owner == 0) ? m0_wstrb : m1_wstrb;
            if (mo_owner == 0) begin
                r0 = s_ready || fire; rd0 = fire ? 32'hFFFF_FFFF : s_rdata;
            end else begin
                r1 = s_ready || fire; rd1 = fire ? 32'hFFFF_FFFF : s_rdata;
            end
        end
        e = {g, sv, r0, r1, rd0, rd1, a, wd, ws, mo_irq, mo_src};
    endtask

    task automatic model_step(input bit fire);
        bit v;
        mo_irq = 0;
        if (mo_owner < 0) begin
            mo_wait = 0;
            if (m0_valid && m1_valid) mo_owner = mo_pref;
            else if (m0_valid)        mo_owner = 0;
            else if (m1_valid)        mo_owner = 1;
        end else begin
            v = (mo_owner == 0) ? m0_valid : m1_valid;
            if (!v) begin
                mo_owner = -1;
            end else if (s_ready) begin
                mo_pref = 1 - mo_owner; mo_owner = -1;
            end else if (fire) begin
                mo_irq = 1; mo_src = (mo_owner == 1); mo_pref = 1 - mo_owner; mo_owner = -1;
            end else begin
                mo_wait++;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];

    initial begin
        logic [159:0] e;
        bit r0, r1, fire, p0, p1, stall;

        tbl[0]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 1, 1, 32'hA000_0000, 2'b01, 1, 1, 0, 32'hA000_0000, 32'h0, 32'h100);
        tbl[2]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[3]  = mk(1, 1, 1, 32'hA111_1111, 2'b10, 1, 0, 1, 32'h0, 32'hA111_1111, 32'h200);
        tbl[4]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[5]  = mk(1, 1, 1, 32'hA222_2222, 2'b01, 1, 1, 0, 32'hA222_2222, 32'h0, 32'h100);
        tbl[6]  = mk(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'hA333_3333, 2'b10, 1, 0, 1, 32'h0, 32'hA333_3333, 32'h200);
        tbl[8]  = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tbl[10] = mk(1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h100);
        tbl[11] = mk(1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h100);
        tbl[12] = mk(1, 0, 1, 32'h1234_5678, 2'b01, 1, 1, 0, 32'h1234_5678, 32'h0, 32'h100);
        tbl[13] = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0);

        resetn = 0; comb_ready = 0; s_ready_drv = 0; s_rdata = 0;
        m0_valid = 0; m0_addr = 32'h100; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 32'h200; m1_wdata = 0; m1_wstrb = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {grant, s_valid, m0_ready, m1_ready, timeout_irq, timeout_src,
                            m0_rdata, m1_rdata, s_addr}, '0);
        resetn = 1;
        next_cycle();

        // Arbitration order, rr alternation and lone-m0 read with 2-cycle slave wait.
        for (int i = 0; i < 14; i++) begin
            m0_valid = tbl[i].v0; m1_valid = tbl[i].v1;
            s_ready_drv = tbl[i].srdy; s_rdata = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {grant, s_valid, m0_ready, m1_ready, m0_rdata, m1_rdata, s_addr},
                {tbl[i].e_grant, tbl[i].e_sv, tbl[i].e_r0, tbl[i].e_r1,
                 tbl[i].e_rd0, tbl[i].e_rd1, tbl[i].e_addr});
            $display("[TB] vec %0d grant=%b s_valid=%b m0_ready=%b m1_ready=%b",
                     i, grant, s_valid, m0_ready, m1_ready);
            next_cycle();
        end

        // m1 write with a combinational slave: ready in the first granted cycle.
        m1_valid = 1; m1_wstrb = 4'b0011; m1_wdata = 32'hAABB_CCDD; comb_ready = 1; s_ready_drv = 0;
        @(negedge clk);
        chk("wr_idle", {grant, m1_ready}, {2'b00, 1'b0});
        next_cycle();
        @(negedge clk);
        chk("wr_fwd", {grant, s_valid, m1_ready, m0_ready, s_wstrb, s_wdata},
                      {2'b10, 1'b1, 1'b1, 1'b0, 4'b0011, 32'hAABB_CCDD});
        $display("[TB] m1 write wstrb=%b wdata=%h", s_wstrb, s_wdata);
        next_cycle();
        m1_valid = 0; comb_ready = 0; m1_wstrb = 0; m1_wdata = 0;

        // m1 read with the slave stalled: watchdog completes on the 8th granted cycle.
        m1_valid = 1; s_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("to_idle", grant, 2'b00);
        next_cycle();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k < TO)
                chk($sformatf("to_wait%0d", k), {m1_ready, s_valid, grant, timeout_irq}, {1'b0, 1'b1, 2'b10, 1'b0});
            else
                chk("to_fire", {m1_ready, s_valid, m1_rdata, timeout_irq}, {1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0});
            next_cycle();
        end
        m1_valid = 0;
        @(negedge clk);
        chk("to_irq", {timeout_irq, timeout_src, grant}, {1'b1, 1'b1, 2'b00});
        $display("[TB] m1 read timed out irq=%b src=%b", timeout_irq, timeout_src);
        next_cycle();
        @(negedge clk);
        chk("to_irq_off", timeout_irq, 1'b0);
        next_cycle();

        // s_ready arriving on the timeout cycle completes normally.
        m0_valid = 1; s_ready_drv = 0;
        next_cycle();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) begin s_ready_drv = 1; s_rdata = 32'h5555_AAAA; end
            @(negedge clk);
            if (k == TO)
                chk("race_done", {m0_ready, s_valid, m0_rdata}, {1'b1, 1'b1, 32'h5555_AAAA});
            next_cycle();
        end
        m0_valid = 0; s_ready_drv = 0;
        @(negedge clk);
        chk("race_noirq", {timeout_irq, timeout_src, grant}, {1'b0, 1'b1, 2'b00});
        $display("[TB] m0 read completed on timeout cycle rdata=5555aaaa");
        next_cycle();

        // Asynchronous reset in the middle of a GNT0 transfer.
        m0_valid = 1;
        next_cycle();
        @(negedge clk);
        chk("rst_pre", {grant, s_valid}, {2'b01, 1'b1});
        #2 resetn = 0;
        #1 chk("rst_async", {grant, s_valid, m0_ready, timeout_src}, {2'b00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        resetn = 1;
        next_cycle();
        chk("rst_regrant", {grant, s_valid}, {2'b01, 1'b1});
        $display("[TB] reset mid-transfer, m0 re-granted grant=%b", grant);
        m0_valid = 0;
        next_cycle();

        // Randomized traffic against the reference model.
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        next_cycle();
        model_reset();
        p0 = 0; p1 = 0; stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom_range(0, 15));
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
            end
            m0_valid = p0; m1_valid = p1;
            if (c % 24 == 0) stall = ($urandom_range(0, 2) == 0);
            s_ready_drv = stall ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            @(negedge clk);
            model_eval(e, r0, r1, fire);
            chk($sformatf("rand%0d", c),
                {grant, s_valid, m0_ready, m1_ready, m0_rdata, m1_rdata, s_addr, s_wdata, s_wstrb,
                 timeout_irq, timeout_src}, e);
            model_step(fire);
            if (r0) p0 = 0;
            if (r1) p1 = 0;
            if (p0 && $urandom_range(0, 99) == 0) p0 = 0;
            if (p1 && $urandom_range(0, 99) == 0) p1 = 0;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
